// File: rtl/time_set_ctrl.sv
// time_set_ctrl: UART "SHHMMSS\r" time-set command parser driving BCD reconfiguration of the clock counters
// Ports: clk, resett (sync, active-low); rx_data/rx_valid in; tx_data/tx_valid/tx_ready response handshake;
//        hour_m..sec_l BCD digits, reconfig_en load strobe, err strobe, busy (not IDLE).
// Build option: TIME_SET_CTRL_ACK_EN enables the RESP state with 'K'/'E' response bytes.
module time_set_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_W = 26
) (
  input  logic       clk,
  input  logic       resett,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] hour_m,
  output logic [3:0] hour_l,
  output logic [3:0] min_m,
  output logic [3:0] min_l,
  output logic [3:0] sec_m,
  output logic [3:0] sec_l,
  output logic       reconfig_en,
  output logic       err,
  output logic       busy
);
`ifdef TIME_SET_CTRL_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DIG, TERM, RESP} state_t;
  state_t state;
  logic [2:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0] sh [6];
  logic is_dig, bad;
  assign busy = state != IDLE;
  assign is_dig = rx_data >= 8'h30 && rx_data <= 8'h39;
  // hour tens <= 2, hours <= 23 when tens is 2, minute/second tens <= 5
  assign bad = !is_dig || (idx == 3'd0 && rx_data > 8'h32) ||
               (idx == 3'd1 && sh[0] == 4'd2 && rx_data > 8'h33) ||
               ((idx == 3'd2 || idx == 3'd4) && rx_data > 8'h35);
  always_ff @(posedge clk) begin
    if (!resett) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      sh <= '{default: '0};
      {hour_m, hour_l, min_m, min_l, sec_m, sec_l} <= '0;
      reconfig_en <= 1'b0;
      err <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      reconfig_en <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_valid && rx_data == 8'h53) begin
            state <= DIG;
            idx <= '0;
            sh <= '{default: '0};
          end
        end
        DIG, TERM: begin
          if (rx_valid) begin
            cnt <= '0;
            if (rx_data == 8'h53) begin
              state <= DIG;
              idx <= '0;
              sh <= '{default: '0};
            end else if (state == TERM && rx_data == 8'h0D) begin
              {hour_m, hour_l, min_m, min_l, sec_m, sec_l} <= {sh[0], sh[1], sh[2], sh[3], sh[4], sh[5]};
              reconfig_en <= 1'b1;
              state <= ACK ? RESP : IDLE;
              tx_valid <= ACK;
              tx_data <= ACK ? 8'h4B : 8'h00;
            end else if (state == TERM || bad) begin
              err <= 1'b1;
              state <= ACK ? RESP : IDLE;
              tx_valid <= ACK;
              tx_data <= ACK ? 8'h45 : 8'h00;
            end else begin
              sh[idx] <= rx_data[3:0];
              idx <= idx == 3'd5 ? idx : idx + 3'd1;
              state <= idx == 3'd5 ? TERM : DIG;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt <= '0;
            err <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
`ifdef TIME_SET_CTRL_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif
  logic clk = 1'b0, resett = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic tx_valid, reconfig_en, err, busy;
  logic [3:0] hour_m, hour_l, min_m, min_l, sec_m, sec_l;
  logic [23:0] digits;
  int total = 0, passed = 0;
  assign digits = {hour_m, hour_l, min_m, min_l, sec_m, sec_l};
  always #5 clk = ~clk;
  time_set_ctrl #(.TIMEOUT_CYCLES(100), .CNT_W(7)) dut (
    .clk(clk), .resett(resett), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .hour_m(hour_m), .hour_l(hour_l), .min_m(min_m), .min_l(min_l), .sec_m(sec_m), .sec_l(sec_l),
    .reconfig_en(reconfig_en), .err(err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  initial begin
    tick(2);
    chk("rst_digits", digits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_reconf", reconfig_en, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    resett = 1'b1;
    tick();
    send_str("S12345");
    chk("busy_mid", busy, 1);
    send_str("6");
    chk("no_reconf_pre_cr", reconfig_en, 0);
    send(8'h0D);
    chk("ok_reconf", reconfig_en, 1);
    chk("ok_digits", digits, 24'h123456);
    chk("ok_err", err, 0);
    chk("ok_txv", tx_valid, ACK);
    chk("ok_txd", tx_data, ACK ? 8'h4B : 8'h00);
    chk("ok_busy", busy, ACK);
    tick();
    chk("ok_reconf_1cyc", reconfig_en, 0);
    chk("ok_busy_after", busy, 0);
    chk("ok_txv_after", tx_valid, 0);
    send_str("S2");
    chk("hr23_no_err", err, 0);
    send_str("4");
    chk("hr24_err", err, 1);
    chk("hr24_txd", tx_data, ACK ? 8'h45 : 8'h00);
    chk("hr24_busy", busy, ACK);
    tick();
    chk("hr24_err_1cyc", err, 0);
    chk("hr24_idle", busy, 0);
    send_str("5959");
    send(8'h0D);
    chk("tail_ignored_busy", busy, 0);
    chk("tail_no_reconf", reconfig_en, 0);
    chk("err_digits_kept", digits, 24'h123456);
    send_str("S12S235959");
    chk("restart_no_err", err, 0);
    send(8'h0D);
    chk("restart_reconf", reconfig_en, 1);
    chk("restart_digits", digits, 24'h235959);
    tick();
    send_str("S196");
    chk("min_tens_err", err, 1);
    tick();
    send_str("S19599");
    chk("sec_tens_err", err, 1);
    tick();
    send_str("S3");
    chk("hr_tens_err", err, 1);
    tick();
    send_str("S12345A");
    chk("nondigit_err", err, 1);
    tick();
    send_str("S123456X");
    chk("term_err", err, 1);
    chk("term_err_digits", digits, 24'h235959);
    tick();
    send_str("S190000");
    send(8'h0D);
    chk("hr19_digits", digits, 24'h190000);
    tick();
    send_str("S12");
    tick(99);
    chk("to_not_yet_err", err, 0);
    chk("to_not_yet_busy", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_idle", busy, 0);
    chk("to_txv", tx_valid, 0);
    tick();
    chk("to_err_1cyc", err, 0);
    chk("to_digits", digits, 24'h190000);
    send_str("S12");
    tick(99);
    send_str("3");
    chk("to_byte_wins_err", err, 0);
    chk("to_byte_wins_busy", busy, 1);
    send_str("456");
    send(8'h0D);
    chk("to_byte_wins_load", digits, 24'h123456);
    tick();
    tx_ready = 1'b0;
    send_str("S123456");
    send(8'h0D);
    chk("hold_reconf", reconfig_en, 1);
    send_str("S000000");
    send(8'h0D);
    tick(4);
    chk("hold_txv", tx_valid, ACK);
    chk("hold_txd", tx_data, ACK ? 8'h4B : 8'h00);
    chk("hold_busy", busy, ACK);
    chk("hold_digits", digits, ACK ? 24'h123456 : 24'h000000);
    tx_ready = 1'b1;
    tick();
    chk("hold_release_busy", busy, 0);
    chk("hold_release_txv", tx_valid, 0);
    send_str("S1234");
    resett = 1'b0;
    tick();
    chk("midrst_digits", digits, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_txv", tx_valid, 0);
    rx_data = 8'h53;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("rst_dominates_rx", busy, 0);
    resett = 1'b1;
    send_str("S000001");
    send(8'h0D);
    chk("post_rst_reconf", reconfig_en, 1);
    chk("post_rst_digits", digits, 24'h000001);
    tick();
    tx_ready = 1'b0;
    send_str("S000002");
    send(8'h0D);
    resett = 1'b0;
    tx_ready = 1'b1;
    tick();
    chk("resp_rst_txv", tx_valid, 0);
    chk("resp_rst_busy", busy, 0);
    chk("resp_rst_digits", digits, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000000, inter-byte timeout in clk cycles (1 s at 50 MHz).
REQ-002 Parameter CNT_W, default 26, width of timeout counter; SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 resett  input  1  synchronous reset, active-low (0 = reset).
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  output  8  response byte to UART transmitter.
REQ-008 tx_valid  output  1  response byte pending.
REQ-009 tx_ready  input  1  transmitter accepts tx_data when tx_valid and tx_ready both high.
REQ-010 hour_m, hour_l, min_m, min_l, sec_m, sec_l  output  4 each  BCD reconfiguration digits for the clock counters.
REQ-011 reconfig_en  output  1  one-cycle load strobe to the clock counters.
REQ-012 err  output  1  one-cycle strobe on rejected command or timeout.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Command format: 'S' (0x53), six ASCII digits H H M M S S (0x30-0x39), CR (0x0D); eight bytes.
REQ-015 FSM states SHALL be IDLE, DIG, TERM, RESP; digit index 0..5 held in a 3-bit register.
REQ-016 IDLE: byte 0x53 -> DIG, index 0, digit shadow registers cleared; any other byte ignored.
REQ-017 DIG: each byte checked: non-digit, index0 > '2', index0='2' and index1 > '3', index2 > '5', index4 > '5' -> error.
REQ-018 DIG: valid digit stored (byte minus 0x30) in shadow register of current index; index 5 -> TERM, else index+1.
REQ-019 Byte 0x53 received in DIG or TERM SHALL restart collection (index 0, shadows cleared), no error.
REQ-020 TERM: 0x0D -> success; any other byte -> error.
REQ-021 Success: cycle after CR accepted, outputs load shadow values and reconfig_en high exactly one cycle.
REQ-022 Digit outputs SHALL hold last successfully loaded values; never change on error, timeout or partial command.
REQ-023 Error: err high one cycle (cycle after offending byte), FSM -> RESP with 'E' (0x45).
REQ-024 Success response byte 'K' (0x4B), FSM -> RESP same cycle as reconfig_en.
REQ-025 RESP: tx_valid high, tx_data stable until handshake; on tx_valid&tx_ready -> IDLE next cycle.
REQ-026 RESP: rx_valid bytes SHALL be dropped, including 0x53.
REQ-027 Timeout counter cleared on every accepted rx byte in DIG/TERM; counts every cycle in DIG/TERM without rx_valid.
REQ-028 Counter reaching TIMEOUT_CYCLES-1 -> IDLE next cycle, err pulse one cycle, no response byte.
REQ-029 rx_valid in the same cycle as timeout expiry: byte wins, counter cleared, no timeout.
REQ-030 Counter held at 0 in IDLE and RESP.

Reset
REQ-031 resett=0 at a rising edge: FSM IDLE, index 0, counter 0, shadows 0, all six digit outputs 0, reconfig_en 0, err 0, tx_valid 0, tx_data 0x00, busy 0.
REQ-032 Reset mid-command or mid-RESP SHALL abandon the command with no reconfig_en, err or tx byte.
REQ-033 Reset dominates rx_valid and tx_ready in the same cycle.

Configuration
REQ-034 Macro TIME_SET_CTRL_ACK_EN defined: RESP state and 'K'/'E' responses per REQ-023..026.
REQ-035 Macro undefined: RESP state absent, success/error go directly to IDLE, tx_valid tied 0, tx_data tied 0x00; all other behaviour identical.

Verification
REQ-036 Send "S123456\r", tx_ready=1 -> one reconfig_en pulse, digits 1,2,3,4,5,6, tx byte 0x4B, busy low after handshake.
REQ-037 Send "S245959\r" -> err pulse after the '4' byte, tx 0x45, digit outputs unchanged from prior load.
REQ-038 Send "S12S235959\r" -> no error, digits 2,3,5,9,5,9 loaded, single 0x4B.
REQ-039 TIMEOUT_CYCLES=100, send "S12" then idle 100 cycles -> err pulse, IDLE, tx_valid stays 0; byte at cycle 99 instead -> no timeout.
REQ-040 Success with tx_ready=0 for 20 cycles while sending "S000000\r" -> tx_valid/0x4B held, bytes dropped, IDLE one cycle after tx_ready rises, digits stay 1,2,3,4,5,6.
REQ-041 resett=0 after "S1234" -> all outputs 0; following "S000001\r" accepted normally.
